// File: rtl/pipe_delay_line.sv
// pipe_delay_line: chain of DEPTH pipeline registers with a run-time latency tap.
// LAT selects the tap (0 = combinational bypass). LAT values above DEPTH are
// clamped to DEPTH and set the sticky lat_err flag.
// A valid bit travels with every data stage. CE advances the chain. flush
// clears the chain but leaves lat_err alone.
// Optional build macro PIPE_INIT_EN: when defined, rst/flush load every data
// stage with INIT; otherwise data stages clear to zero.
module pipe_delay_line #(
  parameter int               WIDTH = 18,
  parameter int               DEPTH = 4,
  parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}},
  localparam int              LAT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CE,
  input  logic             flush,
  input  logic [LAT_W-1:0] LAT,
  input  logic [WIDTH-1:0] D,
  input  logic             D_vld,
  output logic [WIDTH-1:0] out,
  output logic             out_vld,
  output logic             lat_err
);

  // Index width into the stage array; kept at least 1 bit for DEPTH = 1.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LAT_W-1:0] DEPTH_L = LAT_W'(DEPTH);

`ifdef PIPE_INIT_EN
  localparam logic [WIDTH-1:0] RST_VAL = INIT;
`else
  // INIT is masked off so the data stages clear to zero in this build.
  localparam logic [WIDTH-1:0] RST_VAL = INIT & {WIDTH{1'b0}};
`endif

  logic [WIDTH-1:0] stage_data_r [DEPTH];
  logic [DEPTH-1:0] stage_vld_r;
  logic             lat_err_r;

  logic             lat_over_s;
  logic [LAT_W-1:0] lat_eff_s;
  logic [IDX_W-1:0] tap_idx_s;
  logic [WIDTH-1:0] out_s;
  logic             out_vld_s;

  // Clamp the requested latency to the physical depth and derive the tap index.
  always_comb begin
    lat_over_s = 1'b0;
    lat_eff_s  = LAT;
    tap_idx_s  = {IDX_W{1'b0}};
    if (LAT > DEPTH_L) begin
      lat_over_s = 1'b1;
      lat_eff_s  = DEPTH_L;
    end else begin
      lat_over_s = 1'b0;
      lat_eff_s  = LAT;
    end
    if (lat_eff_s != {LAT_W{1'b0}}) begin
      tap_idx_s = IDX_W'(lat_eff_s - {{(LAT_W-1){1'b0}}, 1'b1});
    end else begin
      tap_idx_s = {IDX_W{1'b0}};
    end
  end

  // Stage chain: reset beats flush, flush beats CE, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_data_r[k] <= RST_VAL;
      end
      stage_vld_r <= {DEPTH{1'b0}};
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_data_r[k] <= RST_VAL;
      end
      stage_vld_r <= {DEPTH{1'b0}};
    end else if (CE) begin
      stage_data_r[0] <= D;
      stage_vld_r[0]  <= D_vld;
      for (int k = 1; k < DEPTH; k++) begin
        stage_data_r[k] <= stage_data_r[k-1];
        stage_vld_r[k]  <= stage_vld_r[k-1];
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_data_r[k] <= stage_data_r[k];
      end
      stage_vld_r <= stage_vld_r;
    end
  end

  // Sticky out-of-range latency flag; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_err_r <= 1'b0;
    end else if (lat_over_s) begin
      lat_err_r <= 1'b1;
    end else begin
      lat_err_r <= lat_err_r;
    end
  end

  // Output tap: zero latency bypasses the chain combinationally.
  always_comb begin
    out_s     = D;
    out_vld_s = D_vld;
    if (lat_eff_s == {LAT_W{1'b0}}) begin
      out_s     = D;
      out_vld_s = D_vld;
    end else begin
      out_s     = stage_data_r[tap_idx_s];
      out_vld_s = stage_vld_r[tap_idx_s];
    end
  end

  assign out     = out_s;
  assign out_vld = out_vld_s;
  assign lat_err = lat_err_r;

endmodule

// File: tb/tb_pipe_delay_line.sv
// Self-checking bench for pipe_delay_line (WIDTH 18, DEPTH 4).
// Reference model: a history of samples captured on CE edges since the last
// clear. Tap L returns the L-th most recent capture, or the reset value when
// fewer than L captures have happened since the last rst/flush.
module tb_pipe_delay_line;

  localparam int               WIDTH = 18;
  localparam int               DEPTH = 4;
  localparam logic [WIDTH-1:0] INIT  = 18'h2AAAA;
`ifdef PIPE_INIT_EN
  localparam logic [WIDTH-1:0] EXP_RST = INIT;
`else
  localparam logic [WIDTH-1:0] EXP_RST = 18'h00000;
`endif

  logic             clk = 1'b0;
  logic             rst, CE, flush, D_vld;
  logic [2:0]       LAT;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] out;
  logic             out_vld, lat_err;

  int n_vec = 0;
  int n_err = 0;

  // Model state: captured {vld, data} entries, newest first.
  logic [WIDTH:0] hist_q[$];
  logic           err_m = 1'b0;

  pipe_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT(INIT)) dut (
    .clk(clk), .rst(rst), .CE(CE), .flush(flush), .LAT(LAT),
    .D(D), .D_vld(D_vld), .out(out), .out_vld(out_vld), .lat_err(lat_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare DUT outputs against the model given the current inputs.
  task automatic compare_all();
    int L;
    logic [WIDTH-1:0] e_d;
    logic             e_v;
    L = (int'(LAT) > DEPTH) ? DEPTH : int'(LAT);
    if (L == 0) begin
      e_d = D;
      e_v = D_vld;
    end else if (hist_q.size() >= L) begin
      e_d = hist_q[L-1][WIDTH-1:0];
      e_v = hist_q[L-1][WIDTH];
    end else begin
      e_d = EXP_RST;
      e_v = 1'b0;
    end
    check("out", 32'(out), 32'(e_d));
    check("out_vld", 32'(out_vld), 32'(e_v));
    check("lat_err", 32'(lat_err), 32'(err_m));
  endtask

  // Apply the rules of one clock edge to the model.
  task automatic model_edge();
    if (rst) begin
      hist_q.delete();
      err_m = 1'b0;
    end else begin
      if (int'(LAT) > DEPTH) err_m = 1'b1;
      if (flush) begin
        hist_q.delete();
      end else if (CE) begin
        hist_q.push_front({D_vld, D});
        if (hist_q.size() > DEPTH) void'(hist_q.pop_back());
      end
    end
  endtask

  task automatic cycle(input logic r, input logic f, input logic ce, input logic [2:0] lat,
                       input logic [WIDTH-1:0] d, input logic dv);
    rst = r; flush = f; CE = ce; LAT = lat; D = d; D_vld = dv;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; CE = 1'b0; LAT = 3'd2; D = 18'h0; D_vld = 1'b0;
    @(posedge clk);
    model_edge();
    #1;

    // Reset, then bypass (also bypass while in reset).
    cycle(1'b1, 1'b0, 1'b0, 3'd2, 18'h00000, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 3'd2, 18'h00000, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 3'd0, 18'h00123, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 3'd0, 18'h00155, 1'b1);
    check("bypass_155", 32'(out), 32'h155);

    // Latency 3 streaming.
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b0, 1'b1, 3'd3, 18'(i), 1'b1);
    for (int i = 0; i < 5; i++)  cycle(1'b0, 1'b0, 1'b1, 3'd3, 18'h00000, 1'b0);

    // CE stall at latency 2.
    cycle(1'b0, 1'b0, 1'b1, 3'd2, 18'h0000A, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 3'd2, 18'h0000B, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 3'd2, 18'h0000B, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 3'd2, 18'h00000, 1'b0);

    // Flush with CE on the same edge: 0x3FF must never appear.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 3'd4, 18'(16 + i), 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 3'd4, 18'h003FF, 1'b1);
    for (int L = 1; L <= 4; L++) cycle(1'b0, 1'b0, 1'b0, 3'(L), 18'h00000, 1'b0);
    check("flush_vld", 32'(out_vld), 32'h0);

    // Out-of-range latency: clamp, sticky through flush, cleared by rst.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 3'd4, 18'(32 + i), 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 3'd7, 18'h00000, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 3'd7, 18'h00000, 1'b0);
    check("clamp_out", 32'(out), 32'd32);
    check("err_set", 32'(lat_err), 32'h1);
    cycle(1'b0, 1'b1, 1'b0, 3'd1, 18'h00000, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 3'd1, 18'h00000, 1'b0);
    check("err_after_flush", 32'(lat_err), 32'h1);
    cycle(1'b1, 1'b0, 1'b0, 3'd1, 18'h00000, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 3'd1, 18'h00000, 1'b0);
    check("err_after_rst", 32'(lat_err), 32'h0);
    check("rst_val", 32'(out), 32'(EXP_RST));

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic r, f, ce, dv;
      logic [2:0] lat;
      r   = ($urandom_range(0, 49) == 0);
      f   = ($urandom_range(0, 19) == 0);
      ce  = ($urandom_range(0, 3) != 0);
      dv  = $urandom_range(0, 1) == 1;
      lat = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      cycle(r, f, ce, lat, 18'($urandom), dv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
